// File: rtl/f_accum_reduce.sv
// f_accum_reduce: multi-channel windowed max/min/saturating-sum reduction; define F_ACCUM_REDUCE_SUM_EN to compile in the sum datapath
module f_accum_reduce #(
  parameter int DATA_W   = 32,
  parameter int DELAY_W  = 7,
  parameter int CHANNELS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [1:0]         mode,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic               valid0
);
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int N = 2 ** CH_W;
  logic [DELAY_W-1:0] delay, elem, stride_r;
  logic [CH_W-1:0] ch;
  logic [1:0] mode_r;
  logic [DATA_W-1:0] acc [N];
  logic [DATA_W-1:0] cur, mm, red, nxt;
  logic wrap, last;
  assign cur  = acc[ch];
  assign wrap = ch == CH_W'(CHANNELS - 1);
  assign last = elem == stride_r;
  assign mm   = mode_r == 2'b01 ? ($signed(in0) < $signed(cur) ? in0 : cur)
                                : ($signed(in0) > $signed(cur) ? in0 : cur);
`ifdef F_ACCUM_REDUCE_SUM_EN
  logic [DATA_W:0] sum;
  logic [DATA_W-1:0] sat;
  assign sum = {cur[DATA_W-1], cur} + {in0[DATA_W-1], in0};
  // overflow when the extra sign bit disagrees; clamp toward the true sign
  assign sat = sum[DATA_W] != sum[DATA_W-1] ? {sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}} : sum[DATA_W-1:0];
  assign red = mode_r == 2'b10 ? sat : mm;
`else
  assign red = mm;
`endif
  assign nxt = elem == '0 ? in0 : red;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0     <= '0;
      valid0   <= 1'b0;
      delay    <= '0;
      ch       <= '0;
      elem     <= '0;
      mode_r   <= '0;
      stride_r <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (run) begin
      delay    <= delay0;
      ch       <= '0;
      elem     <= '0;
      mode_r   <= mode;
      stride_r <= strideMinusOne;
      valid0   <= 1'b0;
    end else if (running && delay != '0) begin
      delay  <= delay - 1'b1;
      valid0 <= 1'b0;
    end else if (running) begin
      acc[ch] <= nxt;
      out0    <= nxt;
      valid0  <= last;
      ch      <= wrap ? '0 : ch + 1'b1;
      if (wrap) elem <= last ? '0 : elem + 1'b1;
    end else begin
      valid0 <= 1'b0;
    end
  end
endmodule
